// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the two-requester AXI4 memory arbiter.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_RSP
  } rd_state_t;

  localparam int REQ_WR = 0;
  localparam int REQ_RD = 1;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DEPTH      = 1024;

endpackage

// File: rtl/axi_mem_rr_arb.sv
// 2-way round-robin grant: combinational grant, zero latency, no backpressure of its own.
// The pointer names the owner and flips only on a contested grant.
module axi_mem_rr_arb
  import axi_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'(REQ_WR);
    end else if (&req) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/axi4_mem_arbiter.sv
// Shares a single-port memory between write and read requesters; command registered one cycle after accept,
// read response held under rd_rsp_ready backpressure. Optional AXI_MEM_ARB_RANGE_CHECK_EN suppresses addr >= DEPTH.
module axi4_mem_arbiter
  import axi_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_rsp_valid,
  input  logic                  rd_rsp_ready,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,
  output logic                  rd_rsp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_chk
    $error("axi4_mem_arbiter: DEPTH must be in 1..2**ADDR_WIDTH");
  end

  rd_state_t  rd_state, rd_state_nxt;
  logic [1:0] req, gnt;
  logic       wr_in_range, rd_in_range;

  // Reads are only eligible with no read outstanding; writes are always eligible.
  assign req[REQ_WR] = wr_req_valid;
  assign req[REQ_RD] = rd_req_valid && (rd_state == RD_IDLE);

  axi_mem_rr_arb u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign wr_req_ready = gnt[REQ_WR];
  assign rd_req_ready = gnt[REQ_RD];

`ifdef AXI_MEM_ARB_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  logic rd_oor;
  logic rsp_err;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_oor  <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (gnt[REQ_RD]) begin
        rd_oor <= ~rd_in_range;
      end
      if (rd_state == RD_WAIT) begin
        rsp_err <= rd_oor;
      end
    end
  end

  assign rd_rsp_err = rsp_err;
`else
  assign wr_in_range = 1'b1;
  assign rd_in_range = 1'b1;
  assign rd_rsp_err  = 1'b0;
`endif

  // Address/data hold their last values whenever no command is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= (gnt[REQ_WR] && wr_in_range) || (gnt[REQ_RD] && rd_in_range);
      mem_we <= gnt[REQ_WR] && wr_in_range;
      if (gnt[REQ_WR] && wr_in_range) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end else if (gnt[REQ_RD] && rd_in_range) begin
        mem_addr <= rd_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_IDLE;
    end else begin
      rd_state <= rd_state_nxt;
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE:  if (gnt[REQ_RD]) rd_state_nxt = RD_ISSUE;
      RD_ISSUE: rd_state_nxt = RD_WAIT;
      RD_WAIT:  rd_state_nxt = RD_RSP;
      RD_RSP:   if (rd_rsp_ready) rd_state_nxt = RD_IDLE;
      default:  rd_state_nxt = RD_IDLE;
    endcase
  end

  // mem_rdata is valid during RD_WAIT; capture it there and hold through RD_RSP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_rsp_data <= '0;
    end else if (rd_state == RD_WAIT) begin
`ifdef AXI_MEM_ARB_RANGE_CHECK_EN
      rd_rsp_data <= rd_oor ? '0 : mem_rdata;
`else
      rd_rsp_data <= mem_rdata;
`endif
    end
  end

  assign rd_rsp_valid = (rd_state == RD_RSP);

endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// Directed bench for axi4_mem_arbiter: read responses checked by a scoreboard monitor, issue/grant checked inline.
module tb_axi4_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
`ifdef AXI_MEM_ARB_RANGE_CHECK_EN
  localparam int DEP = 512;
`else
  localparam int DEP = 1024;
`endif
  localparam logic [AW-1:0] TOP_A = AW'(DEP - 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req_valid, wr_req_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_rsp_valid, rd_rsp_ready;
  logic [DW-1:0] rd_rsp_data;
  logic          rd_rsp_err;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  axi4_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_addr      (rd_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_ready (rd_rsp_ready),
    .rd_rsp_data  (rd_rsp_data),
    .rd_rsp_err   (rd_rsp_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Behavioural single-port memory with one-cycle read latency.
  logic [DW-1:0] mem_arr [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    int            acc;
  } rsp_t;
  rsp_t sb[$];

  // Monitor: pops one expectation per response, checks latency, content and hold.
  int   en_cnt = 0;
  bit   in_rsp = 1'b0;
  bit   have_exp = 1'b0;
  rsp_t cur;
  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      in_rsp = 1'b0;
    end else begin
      if (mem_en) en_cnt++;
      if (rd_rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1'b1;
          if (sb.size() == 0) begin
            n_chk++;
            have_exp = 1'b0;
            $display("FAIL spurious_rsp: got response data %h with no read outstanding", rd_rsp_data);
          end else begin
            cur = sb.pop_front();
            have_exp = 1'b1;
            chk("rsp_latency", 32'(cyc - cur.acc), 32'd3);
          end
        end
        if (have_exp) begin
          chk("rsp_data", rd_rsp_data, cur.d);
          chk("rsp_err", 32'(rd_rsp_err), 32'(cur.e));
        end
        chk("rd_req_ready_in_rsp", 32'(rd_req_ready), 32'd0);
        if (rd_rsp_ready) in_rsp = 1'b0;
      end
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit cmd);
    int t = 0;
    wr_req_valid = 1'b1; wr_addr = a; wr_data = d;
    #1;
    while (!wr_req_ready && t < 20) begin @(negedge clk); #1; t++; end
    chk("wr_accept", 32'(wr_req_ready), 32'd1);
    @(negedge clk);
    wr_req_valid = 1'b0;
    #1;
    chk("wr_mem_en", 32'(mem_en), 32'(cmd));
    if (cmd) begin
      chk("wr_mem_we", 32'(mem_we), 32'd1);
      chk("wr_mem_addr", 32'(mem_addr), 32'(a));
      chk("wr_mem_wdata", mem_wdata, d);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit e, input bit push, input bit cmd);
    int t = 0;
    rsp_t r;
    rd_req_valid = 1'b1; rd_addr = a;
    #1;
    while (!rd_req_ready && t < 20) begin @(negedge clk); #1; t++; end
    chk("rd_accept", 32'(rd_req_ready), 32'd1);
    if (push) begin r.d = d; r.e = e; r.acc = cyc; sb.push_back(r); end
    @(negedge clk);
    rd_req_valid = 1'b0;
    #1;
    chk("rd_mem_en", 32'(mem_en), 32'(cmd));
    if (cmd) begin
      chk("rd_mem_we", 32'(mem_we), 32'd0);
      chk("rd_mem_addr", 32'(mem_addr), 32'(a));
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || rd_rsp_valid) && t < 40) begin @(negedge clk); #1; t++; end
    chk("drain_done", 32'(t < 40), 32'd1);
  endtask

  logic [1:0] cont_exp [6] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

  initial begin
    int e0;
    rsp_t r;
    rst = 1'b1;
    wr_req_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req_valid = 1'b0; rd_addr = '0;
    rd_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    chk("rst_rsp_data", rd_rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(rd_rsp_err), 32'd0);
    rst = 1'b0;

    // Single write then read-after-write of the same word.
    e0 = en_cnt;
    wr(10'h005, 32'hA5A5_1234, 1'b1);
    rd(10'h005, 32'hA5A5_1234, 1'b0, 1'b1, 1'b1);
    drain();
    chk("single_en_pulses", 32'(en_cnt - e0), 32'd2);

    // Boundary addresses back-to-back, then reads including an alias probe.
    wr(TOP_A, 32'hDEAD_BEEF, 1'b1);
    wr(10'h000, 32'h0BAD_F00D, 1'b1);
    rd(TOP_A, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1);
    rd(10'h000, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b1);
    rd(10'h005, 32'hA5A5_1234, 1'b0, 1'b1, 1'b1);
    drain();

    // Response backpressure: hold 5 cycles with a new read pending.
    rd_rsp_ready = 1'b0;
    rd(TOP_A, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1);
    begin
      int t = 0;
      while (!rd_rsp_valid && t < 10) begin @(negedge clk); #1; t++; end
    end
    rd_req_valid = 1'b1; rd_addr = 10'h000;
    repeat (5) begin
      #1;
      chk("bp_valid_held", 32'(rd_rsp_valid), 32'd1);
      chk("bp_rd_ready_low", 32'(rd_req_ready), 32'd0);
      @(negedge clk);
    end
    rd_rsp_ready = 1'b1;
    #1;
    chk("bp_hs_cycle_ready", 32'(rd_req_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("bp_next_read", 32'(rd_req_ready), 32'd1);
    r.d = 32'h0BAD_F00D; r.e = 1'b0; r.acc = cyc; sb.push_back(r);
    @(negedge clk);
    rd_req_valid = 1'b0;
    drain();

    // Contention from reset: W, R, then writes while the read is in flight.
    wr(10'h020, 32'h1357_2468, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_req_valid = 1'b1; wr_addr = AW'(10'h030 + i); wr_data = 32'hC0DE_0000 + 32'(i);
      rd_req_valid = 1'b1; rd_addr = 10'h020;
      #1;
      chk("cont_gnt", 32'({rd_req_ready, wr_req_ready}), 32'(cont_exp[i]));
      if (rd_req_ready) begin r.d = 32'h1357_2468; r.e = 1'b0; r.acc = cyc; sb.push_back(r); end
      @(negedge clk);
    end
    wr_req_valid = 1'b0; rd_req_valid = 1'b0;
    #1;
    drain();
    rd(10'h032, 32'hC0DE_0002, 1'b0, 1'b1, 1'b1);
    drain();

    // Reset while the read sits in RD_WAIT: no response may survive.
    rd(10'h005, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
    chk("mid_rst_rsp_data", rd_rsp_data, 32'd0);
    rst = 1'b0;
    rd_req_valid = 1'b1; rd_addr = 10'h000;
    #1;
    chk("post_rst_rd_idle", 32'(rd_req_ready), 32'd1);
    r.d = 32'h0BAD_F00D; r.e = 1'b0; r.acc = cyc; sb.push_back(r);
    @(negedge clk);
    rd_req_valid = 1'b0;
    drain();

`ifdef AXI_MEM_ARB_RANGE_CHECK_EN
    // Out-of-range: accepted normally, no memory command, read returns 0 with error.
    e0 = en_cnt;
    wr(10'h200, 32'hFFFF_0000, 1'b0);
    rd(10'h200, 32'h0, 1'b1, 1'b1, 1'b0);
    drain();
    chk("oor_no_en", 32'(en_cnt - e0), 32'd0);
    rd(10'h000, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b1);
    drain();
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
